// File: rtl/mio_bus_responder.sv
// mio_bus_responder
// Target-side responder for the multi-cycle CPU's MIO bus. A request
// (CPU_MIO with mem_w, Addr_in and Data_in) is decoded to a word RAM,
// an LED register, a switch port or a free-running counter. The responder
// answers with a one-cycle MIO_ready pulse and registered read data.
//
// Handshake: the CPU raises CPU_MIO and holds every request field stable
// until it sees MIO_ready. The request is taken on the first rising edge
// with CPU_MIO=1 while the FSM is IDLE. MIO_ready is high for exactly one
// cycle (the READY state), and Data_out/bus_err are valid in that cycle.
// One RECOVER cycle follows before another request can be taken.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   CPU_MIO    request strobe
//   mem_w      1 = write, 0 = read
//   Addr_in    byte address, bits [1:0] ignored
//   Data_in    write data
//   switch_in  board switches
//   Data_out   registered read data, held until the next read completes
//   MIO_ready  one-cycle completion pulse
//   bus_err    high with MIO_ready when the address is unmapped
//   led_out    LED register
//   state      FSM state (IDLE=0, ACCESS=1, READY=2, RECOVER=3)
module mio_bus_responder #(
  parameter int unsigned RAM_AW        = 10,
  parameter int unsigned RAM_WAIT      = 2,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [15:0] switch_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic        bus_err,
  output logic [15:0] led_out,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_READY   = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    T_RAM  = 3'd0,
    T_LED  = 3'd1,
    T_SW   = 3'd2,
    T_CNT  = 3'd3,
    T_NONE = 3'd4
  } target_e;

  localparam logic [29:0] LED_WADDR = 30'h3800_0000; // 0xE000_0000 >> 2
  localparam logic [29:0] SW_WADDR  = 30'h3C00_0000; // 0xF000_0000 >> 2
  localparam logic [29:0] CNT_WADDR = 30'h3C00_0001; // 0xF000_0004 >> 2
  localparam logic [3:0]  WAIT_LOAD = 4'((RAM_WAIT == 0) ? 0 : RAM_WAIT - 1);

  state_e      state_q, state_d;
  logic [29:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] data_out_q;
  logic        ready_q;
  logic        err_q;
  logic [15:0] led_q;
  logic [31:0] cnt_q;

  logic [31:0] mem [0:(2**RAM_AW)-1];

  // Byte-lane bits carry no information on a word bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr_in[1:0];

  // The transaction fields in use this cycle: straight from the bus when a
  // request is accepted in IDLE (so a zero-wait access can commit on the
  // same edge that latches it), otherwise the latched copies.
  logic        req_fire;
  logic [29:0] addr_eff;
  logic        we_eff;
  logic [31:0] wdata_eff;
  target_e     tgt;
  logic        commit;
  logic [RAM_AW-1:0] ram_idx;

  assign req_fire  = (state_q == S_IDLE) && CPU_MIO;
  assign addr_eff  = (state_q == S_IDLE) ? Addr_in[31:2] : addr_q;
  assign we_eff    = (state_q == S_IDLE) ? mem_w : we_q;
  assign wdata_eff = (state_q == S_IDLE) ? Data_in : wdata_q;
  assign ram_idx   = addr_eff[RAM_AW-1:0];

  always_comb begin
    tgt = T_NONE;
    if (addr_eff[29:26] == 4'h0)      tgt = T_RAM;
    else if (addr_eff == LED_WADDR)   tgt = T_LED;
    else if (addr_eff == SW_WADDR)    tgt = T_SW;
    else if (addr_eff == CNT_WADDR)   tgt = T_CNT;
  end

  // Next-state logic. commit marks the edge that enters READY: writes land
  // and reads load Data_out on that edge.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (CPU_MIO) begin
          if (tgt == T_RAM && RAM_WAIT > 0) begin
            state_d = S_ACCESS;
            wait_d  = WAIT_LOAD;
          end else begin
            state_d = S_READY;
            commit  = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = S_READY;
          commit  = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_READY:   state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= commit;
      err_q   <= commit && (tgt == T_NONE);

      if (req_fire) begin
        addr_q  <= Addr_in[31:2];
        we_q    <= mem_w;
        wdata_q <= Data_in;
      end

      // A completing counter write takes priority over the increment.
      if (commit && we_eff && tgt == T_CNT) cnt_q <= wdata_eff;
      else                                  cnt_q <= cnt_q + 32'd1;

      if (commit && we_eff && tgt == T_LED) led_q <= wdata_eff[15:0];

      if (commit && !we_eff) begin
        unique case (tgt)
          T_RAM:   data_out_q <= mem[ram_idx];
          T_LED:   data_out_q <= {16'b0, led_q};
          T_SW:    data_out_q <= {16'b0, switch_in};
          T_CNT:   data_out_q <= cnt_q;
          default: data_out_q <= UNMAPPED_DATA;
        endcase
      end
    end
  end

  // RAM array has no reset; a reset on the commit edge still blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_eff && tgt == T_RAM) mem[ram_idx] <= wdata_eff;
  end

  assign Data_out  = data_out_q;
  assign MIO_ready = ready_q;
  assign bus_err   = err_q;
  assign led_out   = led_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder. Each request pushes its expected
// {bus_err, Data_out} onto exp_q; the monitor pops and compares on every
// MIO_ready pulse. The driver checks latency, pulse width and led_out.
module tb_mio_bus_responder;

  logic        clk;
  logic        reset;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [15:0] switch_in;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic        bus_err;
  logic [15:0] led_out;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  logic [31:0] exp_dout;
  logic [15:0] exp_led;

  mio_bus_responder #(
    .RAM_AW(10),
    .RAM_WAIT(2),
    .UNMAPPED_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .CPU_MIO(CPU_MIO),
    .mem_w(mem_w),
    .Addr_in(Addr_in),
    .Data_in(Data_in),
    .switch_in(switch_in),
    .Data_out(Data_out),
    .MIO_ready(MIO_ready),
    .bus_err(bus_err),
    .led_out(led_out),
    .state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && MIO_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: Data_out=%h with no request outstanding", Data_out);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("data_out", Data_out, e[31:0]);
        check("bus_err", {31'b0, bus_err}, {31'b0, e[32]});
      end
    end
  end

  // Driver: starts and ends on a negedge, leaving the FSM idle for the next call.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat, input logic err);
    int n;
    exp_q.push_back({err, exp_dout});
    CPU_MIO = 1'b1;
    mem_w   = we;
    Addr_in = addr;
    Data_in = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!MIO_ready && n < 20);
    if (!MIO_ready) begin
      void'(exp_q.pop_back());
      checks++;
      errors++;
      $display("FAIL %s_timeout: no MIO_ready after %0d cycles", name, n);
    end else begin
      check({name, "_latency"}, 32'(n), 32'(lat));
      check({name, "_led"}, {16'b0, led_out}, {16'b0, exp_led});
    end
    CPU_MIO = 1'b0;
    mem_w   = 1'b0;
    @(negedge clk);
    check({name, "_pulse_width"}, {31'b0, MIO_ready}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    CPU_MIO   = 1'b0;
    mem_w     = 1'b0;
    Addr_in   = '0;
    Data_in   = '0;
    switch_in = 16'hA5C3;
    exp_dout  = 32'h0;
    exp_led   = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_data_out", Data_out, 32'h0);
    check("rst_ready", {31'b0, MIO_ready}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_led", {16'b0, led_out}, 32'h0);
    check("rst_state", {30'b0, state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Switch read
    exp_dout = 32'h0000_A5C3;
    do_req("sw_rd", 1'b0, 32'hF000_0000, 32'h0, 1, 1'b0);

    // RAM write, read back, aliased read
    do_req("ram_wr", 1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b0);
    exp_dout = 32'h1234_5678;
    do_req("ram_rd", 1'b0, 32'h0000_0010, 32'h0, 3, 1'b0);
    do_req("ram_alias_rd", 1'b0, 32'h0000_1010, 32'h0, 3, 1'b0);

    // LED write leaves Data_out alone; readback
    exp_led = 16'h00FF;
    do_req("led_wr", 1'b1, 32'hE000_0000, 32'hFFFF_00FF, 1, 1'b0);
    exp_dout = 32'h0000_00FF;
    do_req("led_rd", 1'b0, 32'hE000_0000, 32'h0, 1, 1'b0);

    // Switch write ignored but acknowledged
    do_req("sw_wr", 1'b1, 32'hF000_0000, 32'h0000_1111, 1, 1'b0);
    exp_dout = 32'h0000_A5C3;
    do_req("sw_rd2", 1'b0, 32'hF000_0000, 32'h0, 1, 1'b0);

    // Counter: write FFFF_FFFE on edge S; do_req returns between S+2 and S+3.
    // Two more negedges put the read's sampling edge at S+5, where the
    // counter holds FFFF_FFFE + 4 = 2.
    do_req("cnt_wr", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1, 1'b0);
    repeat (2) @(negedge clk);
    exp_dout = 32'h0000_0002;
    do_req("cnt_rd", 1'b0, 32'hF000_0004, 32'h0, 1, 1'b0);

    // Unmapped read and write
    exp_dout = 32'hDEAD_BEEF;
    do_req("unmap_rd", 1'b0, 32'h8000_0000, 32'h0, 1, 1'b1);
    do_req("unmap_wr", 1'b1, 32'h8000_0000, 32'h0000_7777, 1, 1'b1);
    exp_dout = 32'h0000_00FF;
    do_req("led_rd2", 1'b0, 32'hE000_0000, 32'h0, 1, 1'b0);

    // Reset during ACCESS aborts the RAM write
    do_req("ram_wr20", 1'b1, 32'h0000_0020, 32'hCAFE_0001, 3, 1'b0);
    CPU_MIO = 1'b1;
    mem_w   = 1'b1;
    Addr_in = 32'h0000_0020;
    Data_in = 32'hBAD0_0BAD;
    @(negedge clk);
    check("abort_in_access", {30'b0, state}, 32'd1);
    reset   = 1'b1;
    CPU_MIO = 1'b0;
    mem_w   = 1'b0;
    @(negedge clk);
    check("abort_state_idle", {30'b0, state}, 32'd0);
    check("abort_no_ready", {31'b0, MIO_ready}, 32'd0);
    reset    = 1'b0;
    exp_dout = 32'h0;
    exp_led  = 16'h0;
    repeat (4) @(negedge clk);
    check("abort_led_reset", {16'b0, led_out}, 32'h0);
    exp_dout = 32'hCAFE_0001;
    do_req("ram_rd20", 1'b0, 32'h0000_0020, 32'h0, 3, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
